// File: rtl/gon_pkg.sv
// Shared definitions for the GON multicast scheduler: state encoding and default widths.
package gon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONFIG = 2'd1,
        RUN    = 2'd2
    } gon_state_t;

    localparam int unsigned DEF_ID_LEN    = 4;
    localparam int unsigned DEF_VALUE_LEN = 32;
    localparam int unsigned XFER_CNT_W    = 16;

endpackage

// File: rtl/gon_pkt_fifo.sv
// Synchronous packet FIFO for {tag,value} words; power-of-two depth, pointers wrap naturally.
module gon_pkt_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // Writes are refused while full even if a read retires the head this cycle.
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gon_multicast_scheduler.sv
// One GON X-bus row scheduler: loads controller IDs through the scan chain, then streams
// buffered (tag,value) packets onto the shared bus with an enable/ready handshake.
module gon_multicast_scheduler
    import gon_pkg::*;
#(
    parameter int unsigned ID_LEN     = DEF_ID_LEN,
    parameter int unsigned VALUE_LEN  = DEF_VALUE_LEN,
    parameter int unsigned NUM_CTRL   = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  cfg_id_valid,
    input  logic [ID_LEN-1:0]     cfg_id,
    output logic                  cfg_id_ready,
    output logic                  cfg_done,
    output logic                  set_id,
    output logic [ID_LEN-1:0]     id_out,
    input  logic                  run_en,
    input  logic                  in_valid,
    input  logic [ID_LEN-1:0]     in_tag,
    input  logic [VALUE_LEN-1:0]  in_value,
    output logic                  in_ready,
    output logic [ID_LEN-1:0]     bus_tag,
    output logic [VALUE_LEN-1:0]  bus_value,
    output logic                  bus_enable,
    input  logic                  bus_ready,
    output logic                  busy,
    output logic [XFER_CNT_W-1:0] xfer_cnt
);

    localparam int unsigned PKT_W = ID_LEN + VALUE_LEN;
    localparam int unsigned CW    = $clog2(NUM_CTRL + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CTRL - 1);

    gon_state_t state;
    gon_state_t state_nxt;

    logic [CW-1:0]    shift_cnt;
    logic             cfg_accept;
    logic             cfg_last;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PKT_W-1:0] fifo_head;

    assign cfg_accept = (state == CONFIG) && cfg_id_valid;
    assign cfg_last   = cfg_accept && (shift_cnt == LAST_IDX);
    assign push       = in_valid && in_ready;
    assign pop        = bus_enable && bus_ready;

    gon_pkt_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ({in_tag, in_value}),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cfg_id_ready = 1'b0;
        in_ready     = 1'b0;
        bus_enable   = !fifo_empty;
        bus_tag      = '0;
        bus_value    = '0;
        busy         = (state != IDLE);

        if (!fifo_empty) begin
            bus_tag   = fifo_head[PKT_W-1:VALUE_LEN];
            bus_value = fifo_head[VALUE_LEN-1:0];
        end

        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_nxt = CONFIG;
                end else if (run_en) begin
                    state_nxt = RUN;
                end
            end
            CONFIG: begin
                cfg_id_ready = 1'b1;
                if (cfg_last) begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                in_ready = run_en && !fifo_full;
                // Leave only once drained so the FIFO is always empty in IDLE.
                if (!run_en && fifo_empty) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_cnt <= '0;
            set_id    <= 1'b0;
            cfg_done  <= 1'b0;
            id_out    <= '0;
        end else begin
            set_id   <= cfg_accept;
            cfg_done <= cfg_last;
            if (cfg_accept) begin
                id_out <= cfg_id;
            end
            if (cfg_last) begin
                shift_cnt <= '0;
            end else if (cfg_accept) begin
                shift_cnt <= shift_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_cnt <= '0;
        end else if (pop) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_gon_multicast_scheduler.sv
// Bench for gon_multicast_scheduler: directed and random steps checked against a queue-based model.
module tb_gon_multicast_scheduler;

    localparam int unsigned IDW = 4;
    localparam int unsigned VW  = 32;
    localparam int unsigned NC  = 4;
    localparam int unsigned FD  = 4;
    localparam int unsigned PW  = IDW + VW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_start = 1'b0;
    logic           cfg_id_valid = 1'b0;
    logic [IDW-1:0] cfg_id = '0;
    logic           cfg_id_ready;
    logic           cfg_done;
    logic           set_id;
    logic [IDW-1:0] id_out;
    logic           run_en = 1'b0;
    logic           in_valid = 1'b0;
    logic [IDW-1:0] in_tag = '0;
    logic [VW-1:0]  in_value = '0;
    logic           in_ready;
    logic [IDW-1:0] bus_tag;
    logic [VW-1:0]  bus_value;
    logic           bus_enable;
    logic           bus_ready = 1'b0;
    logic           busy;
    logic [15:0]    xfer_cnt;

    always #5 clk = ~clk;

    gon_multicast_scheduler #(
        .ID_LEN     (IDW),
        .VALUE_LEN  (VW),
        .NUM_CTRL   (NC),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_start    (cfg_start),
        .cfg_id_valid (cfg_id_valid),
        .cfg_id       (cfg_id),
        .cfg_id_ready (cfg_id_ready),
        .cfg_done     (cfg_done),
        .set_id       (set_id),
        .id_out       (id_out),
        .run_en       (run_en),
        .in_valid     (in_valid),
        .in_tag       (in_tag),
        .in_value     (in_value),
        .in_ready     (in_ready),
        .bus_tag      (bus_tag),
        .bus_value    (bus_value),
        .bus_enable   (bus_enable),
        .bus_ready    (bus_ready),
        .busy         (busy),
        .xfer_cnt     (xfer_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: operating mode flags, accepted-ID count, packet queue, transfer total.
    bit             m_cfg;
    bit             m_run;
    int             m_cnt;
    logic           m_set_id;
    logic           m_cfg_done;
    logic [IDW-1:0] m_id_out;
    logic [PW-1:0]  m_q[$];
    logic [15:0]    m_xfer;

    logic [PW-1:0]  src[$];
    bit             feed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_in_ready();
        return m_run && run_en && (m_q.size() < FD);
    endfunction

    task automatic model_reset();
        m_cfg = 0; m_run = 0; m_cnt = 0;
        m_set_id = 1'b0; m_cfg_done = 1'b0; m_id_out = '0;
        m_q.delete();
        m_xfer = '0;
    endtask

    task automatic check_outputs();
        logic [PW-1:0]  head;
        logic [IDW-1:0] etag;
        logic [VW-1:0]  eval;
        etag = '0;
        eval = '0;
        if (m_q.size() > 0) begin
            head = m_q[0];
            etag = head[PW-1:VW];
            eval = head[VW-1:0];
        end
        chk("cfg_id_ready", 32'(cfg_id_ready), 32'(m_cfg));
        chk("in_ready", 32'(in_ready), 32'(model_in_ready()));
        chk("set_id", 32'(set_id), 32'(m_set_id));
        chk("id_out", 32'(id_out), 32'(m_id_out));
        chk("cfg_done", 32'(cfg_done), 32'(m_cfg_done));
        chk("bus_enable", 32'(bus_enable), 32'(m_q.size() > 0));
        chk("bus_tag", 32'(bus_tag), 32'(etag));
        chk("bus_value", 32'(bus_value), 32'(eval));
        chk("busy", 32'(busy), 32'(m_cfg || m_run));
        chk("xfer_cnt", 32'(xfer_cnt), 32'(m_xfer));
    endtask

    // One clock: drive feed, check outputs mid-low-phase, clock edge, advance model.
    task automatic tick(input bit gap = 0);
        bit rdy, ben, acc, last, idle, emp, push, pop;
        if (feed) begin
            if (src.size() > 0 && !gap) begin
                in_valid = 1'b1;
                {in_tag, in_value} = src[0];
            end else begin
                in_valid = 1'b0;
            end
        end
        #1;
        check_outputs();
        rdy  = model_in_ready();
        ben  = m_q.size() > 0;
        emp  = m_q.size() == 0;
        acc  = m_cfg && cfg_id_valid;
        last = acc && (m_cnt == NC - 1);
        idle = !m_cfg && !m_run;
        push = rdy && in_valid;
        pop  = ben && bus_ready;
        @(posedge clk);
        m_set_id   = acc;
        m_cfg_done = last;
        if (acc) m_id_out = cfg_id;
        if (pop) begin
            void'(m_q.pop_front());
            m_xfer = m_xfer + 16'd1;
        end
        if (push) begin
            m_q.push_back({in_tag, in_value});
            if (feed) void'(src.pop_front());
        end
        if (idle) begin
            if (cfg_start) m_cfg = 1;
            else if (run_en) m_run = 1;
        end else if (m_cfg) begin
            if (acc) m_cnt++;
            if (m_cnt == NC) begin
                m_cfg = 0;
                m_cnt = 0;
            end
        end else if (!run_en && emp) begin
            m_run = 0;
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string ctx);
        chk({ctx, ".cfg_id_ready"}, 32'(cfg_id_ready), 32'd0);
        chk({ctx, ".cfg_done"}, 32'(cfg_done), 32'd0);
        chk({ctx, ".set_id"}, 32'(set_id), 32'd0);
        chk({ctx, ".id_out"}, 32'(id_out), 32'd0);
        chk({ctx, ".in_ready"}, 32'(in_ready), 32'd0);
        chk({ctx, ".bus_enable"}, 32'(bus_enable), 32'd0);
        chk({ctx, ".bus_tag"}, 32'(bus_tag), 32'd0);
        chk({ctx, ".bus_value"}, 32'(bus_value), 32'd0);
        chk({ctx, ".busy"}, 32'(busy), 32'd0);
        chk({ctx, ".xfer_cnt"}, 32'(xfer_cnt), 32'd0);
    endtask

    initial begin
        bit [2:0] gaps;
        int bound;
        model_reset();
        feed = 0;

        // Power-on reset
        #1 rst = 1'b0;
        #1 check_all_zero("por");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Config, IDs 3,2,1,0 back-to-back
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            cfg_id_valid = 1'b1;
            cfg_id = IDW'(i);
            tick();
        end
        cfg_id_valid = 1'b0;
        repeat (3) tick();

        // Config with gaps, run_en held high throughout
        gaps = 3'b000;
        cfg_start = 1'b1; run_en = 1'b1; tick(); cfg_start = 1'b0;
        foreach (gaps[k]) gaps[k] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cfg_id_valid = (i != 1) && (i != 4);
            cfg_id = IDW'($urandom);
            tick();
        end
        cfg_id_valid = 1'b0;
        run_en = 1'b0;
        repeat (3) tick();

        // Stream three packets with bus_ready high
        feed = 1;
        run_en = 1'b1; bus_ready = 1'b1;
        tick();
        src.push_back({4'd5, 32'hA});
        src.push_back({4'd6, 32'hB});
        src.push_back({4'd7, 32'hC});
        repeat (8) tick();

        // Backpressure: five packets into a four-deep FIFO
        bus_ready = 1'b0;
        for (int i = 0; i < 5; i++) src.push_back({IDW'(8 + i), 32'(100 + i)});
        repeat (8) tick();
        bus_ready = 1'b1;
        repeat (10) tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus_ready    = ($urandom_range(0, 2) != 0);
            run_en       = ($urandom_range(0, 7) != 0);
            cfg_start    = ($urandom_range(0, 19) == 0);
            cfg_id_valid = $urandom_range(0, 1);
            cfg_id       = IDW'($urandom);
            if (src.size() < 2) src.push_back({IDW'($urandom), 32'($urandom)});
            tick($urandom_range(0, 3) == 0);
        end

        // Flush: finish any config, drain queue, settle in RUN
        cfg_start = 1'b0; cfg_id_valid = 1'b1; run_en = 1'b1; bus_ready = 1'b1;
        src.delete();
        repeat (12) tick();
        cfg_id_valid = 1'b0;
        tick();

        // Drain and exit; cfg_start during RUN must be ignored
        bus_ready = 1'b0;
        src.push_back({4'd3, 32'h1111});
        src.push_back({4'd4, 32'h2222});
        repeat (4) tick();
        bus_ready = 1'b1; run_en = 1'b0; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        bound = 0;
        while ((m_run || m_q.size() > 0) && bound < 20) begin
            tick();
            bound++;
        end
        chk("drain_bound", 32'(bound < 20), 32'd1);
        repeat (2) tick();

        // Reset mid-stream with two packets held
        run_en = 1'b1; bus_ready = 1'b0;
        tick();
        src.push_back({4'd9, 32'hDEAD});
        src.push_back({4'd10, 32'hBEEF});
        repeat (4) tick();
        chk("pre_reset_depth", 32'(bus_enable), 32'd1);
        #2 rst = 1'b0;
        #1 check_all_zero("midrst");
        model_reset();
        src.delete();
        run_en = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
